// File: rtl/score_arbiter.sv
// Score write controller: queues point events per player and serialises them into spaced
// display writes, then sequences game-over hold and reset. SCORE_ARB_ROUND_ROBIN_EN alternates tie grants.
module score_arbiter #(
  parameter int unsigned PEND_W      = 4,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned HOLD_W      = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              point_p1,
  input  logic              point_p2,
  input  logic              game_over,
  output logic              disp_sel,
  output logic              disp_addr,
  output logic              disp_data,
  output logic              game_rst,
  output logic [PEND_W-1:0] pend_p1,
  output logic [PEND_W-1:0] pend_p2,
  output logic              ovf,
  output logic              busy
);

  localparam int unsigned      UPD_W     = PEND_W + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP1,
    S_GAP2,
    S_OVER,
    S_CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic [PEND_W-1:0] pend_p1_q, pend_p1_d;
  logic [PEND_W-1:0] pend_p2_q, pend_p2_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              grant_q, grant_d;
  logic              ovf_q, ovf_d;
  logic              disp_sel_q, disp_sel_d;
  logic              disp_addr_q, disp_addr_d;
  logic              game_rst_q, game_rst_d;
  logic              busy_q, busy_d;
`ifdef SCORE_ARB_ROUND_ROBIN_EN
  logic              last_grant_q, last_grant_d;
`endif

  logic want;
  logic pick;
  logic grant_p1, grant_p2;
  logic freeze;
  logic lost_p1, lost_p2;

  // Saturating counter step; MSB of the result flags a point lost at saturation.
  function automatic logic [UPD_W-1:0] pend_upd(input logic [PEND_W-1:0] cnt,
                                                input logic              inc,
                                                input logic              dec);
    logic [UPD_W-1:0] r;
    r = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == PEND_MAX) r[PEND_W] = 1'b1;
      else                 r = {1'b0, cnt + PEND_W'(1)};
    end else if (dec && !inc) begin
      r = {1'b0, cnt - PEND_W'(1)};
    end
    return r;
  endfunction

  // Grant selection: pick = 0 selects P1, 1 selects P2.
  always_comb begin
    want = (pend_p1_q != '0) || (pend_p2_q != '0);
`ifdef SCORE_ARB_ROUND_ROBIN_EN
    if ((pend_p1_q != '0) && (pend_p2_q != '0)) pick = ~last_grant_q;
    else                                        pick = (pend_p1_q == '0);
`else
    pick = (pend_p1_q == '0);
`endif
  end

  // Next state, hold counter and grant bookkeeping.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    grant_d = grant_q;
`ifdef SCORE_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (game_over) begin
          state_d = S_OVER;
        end else if (want) begin
          state_d = S_ISSUE;
          grant_d = pick;
        end
      end
      S_ISSUE: begin
        state_d = S_GAP1;
`ifdef SCORE_ARB_ROUND_ROBIN_EN
        last_grant_d = grant_q;
`endif
      end
      S_GAP1: state_d = S_GAP2;
      S_GAP2: state_d = game_over ? S_OVER : S_IDLE;
      S_OVER: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_CLEAR;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
        hold_d  = '0;
        grant_d = 1'b0;
`ifdef SCORE_ARB_ROUND_ROBIN_EN
        last_grant_d = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending counters and sticky overflow; frozen to zero through game-over and clear.
  always_comb begin
    grant_p1 = (state_q == S_IDLE) && !game_over && want && !pick;
    grant_p2 = (state_q == S_IDLE) && !game_over && want &&  pick;
    freeze   = (state_d == S_OVER) || (state_q == S_OVER) || (state_q == S_CLEAR);
    {lost_p1, pend_p1_d} = pend_upd(pend_p1_q, point_p1, grant_p1);
    {lost_p2, pend_p2_d} = pend_upd(pend_p2_q, point_p2, grant_p2);
    ovf_d = ovf_q | lost_p1 | lost_p2;
    if (freeze) begin
      pend_p1_d = '0;
      pend_p2_d = '0;
      ovf_d     = ovf_q;
    end
    if (state_q == S_CLEAR) ovf_d = 1'b0;
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    disp_sel_d  = (state_d == S_ISSUE);
    disp_addr_d = (state_d == S_ISSUE) ? grant_d : 1'b0;
    game_rst_d  = (state_d == S_CLEAR);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pend_p1_q   <= '0;
      pend_p2_q   <= '0;
      hold_q      <= '0;
      grant_q     <= 1'b0;
      ovf_q       <= 1'b0;
      disp_sel_q  <= 1'b0;
      disp_addr_q <= 1'b0;
      game_rst_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SCORE_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      pend_p1_q   <= pend_p1_d;
      pend_p2_q   <= pend_p2_d;
      hold_q      <= hold_d;
      grant_q     <= grant_d;
      ovf_q       <= ovf_d;
      disp_sel_q  <= disp_sel_d;
      disp_addr_q <= disp_addr_d;
      game_rst_q  <= game_rst_d;
      busy_q      <= busy_d;
`ifdef SCORE_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign disp_sel  = disp_sel_q;
  assign disp_addr = disp_addr_q;
  assign disp_data = disp_sel_q;
  assign game_rst  = game_rst_q;
  assign pend_p1   = pend_p1_q;
  assign pend_p2   = pend_p2_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: doc/score_arbiter.md
# score_arbiter

Scoreboard write controller between the game logic and the 7-segment score display. It queues point events for both players and serialises them into single-cycle display writes (`sel`/`addr`/`data_in`), spaced so the display's self-clearing increment registers never drop a write. It also detects the display's game-over flag, freezes scoring for a hold period, then issues a one-cycle game reset. Sits in `top` between the collision/goal logic and the display.

## Interface

Parameters:
- `PEND_W`, 4: width of each per-player pending-point counter.
- `HOLD_CYCLES`, 50_000_000: number of cycles spent in game-over before the reset pulse.
- `HOLD_W`, 26: width of the hold counter; must satisfy 2^HOLD_W > HOLD_CYCLES.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `point_p1`  in  1  one-cycle pulse: player 1 scored.
- `point_p2`  in  1  one-cycle pulse: player 2 scored.
- `game_over`  in  1  display `rst_out` (a score reached 99); level.
- `disp_sel`  out  1  display write strobe.
- `disp_addr`  out  1  display player select (0 = P1, 1 = P2).
- `disp_data`  out  1  display `data_in`; 1 whenever `disp_sel` = 1, else 0.
- `game_rst`  out  1  one-cycle reset pulse to the display and game logic.
- `pend_p1`  out  PEND_W  pending P1 points.
- `pend_p2`  out  PEND_W  pending P2 points.
- `ovf`  out  1  sticky: a point was lost to counter saturation.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- States: IDLE, ISSUE, GAP1, GAP2, OVER, CLEAR. All outputs are decoded from registered state and counters.
- Pending counters:
  - +1 on a point pulse; −1 when that player is granted in IDLE→ISSUE.
  - Pulse and grant in the same cycle: the counter is unchanged.
  - Saturate at 2^PEND_W−1. A pulse arriving at saturation is dropped and sets `ovf`.
- IDLE:
  - `game_over` = 1 → OVER.
  - Otherwise, if either pending counter > 0 → ISSUE, latching the grant (see Configuration).
  - Otherwise stay in IDLE.
- ISSUE:
  - `disp_sel` = 1, `disp_data` = 1, `disp_addr` = granted player.
  - Records `last_grant`. → GAP1.
- GAP1: all display outputs 0. → GAP2. Covers the display's increment register and score update.
- GAP2: display outputs 0. → OVER if `game_over`, else → IDLE.
- OVER:
  - Both pending counters cleared on entry; point pulses are ignored.
  - Hold counter increments from 0. When it reaches HOLD_CYCLES−1 → CLEAR.
- CLEAR:
  - `game_rst` = 1 for exactly one cycle.
  - Pending counters, hold counter and `last_grant` are reset. → IDLE.
- `ovf` is cleared only by `rst` or CLEAR.
- `rst` does not drive `game_rst`. `top` ORs `rst` with `game_rst` for the display reset.

## Timing

- Reset values: state IDLE; all outputs 0; `pend_*` = 0; `ovf` = 0; `last_grant` = P2, so P1 wins the first tie.
- `rst` in any state, including mid-OVER, returns the block to reset values on the next edge.
- Latency: a pulse in cycle N makes the pending counter visible in N+1; `disp_sel` is high in N+2 if the FSM was IDLE.
- Write spacing: consecutive `disp_sel` pulses are at least 4 cycles apart (ISSUE, GAP1, GAP2, IDLE).
- Game-over timing: the display score updates 2 cycles after `disp_sel`, so `game_over` is valid in GAP2.
  - No write is ever issued after the write that causes game-over.
- Game-over duration: first OVER cycle to `game_rst` is exactly HOLD_CYCLES cycles. `game_rst` is high in the following cycle, then the FSM is back in IDLE.
- Pulses on both players in the same cycle: both counters increment.

## Configuration

- `SCORE_ARB_ROUND_ROBIN_EN` defined:
  - Both pending counters > 0 → grant the player not in `last_grant` (alternate P1/P2).
  - Only one counter > 0 → grant that player.
- Not defined:
  - Fixed priority: P1 is granted whenever `pend_p1` > 0; P2 only when `pend_p1` = 0.
  - `last_grant` is not implemented.

## Test plan

- Single point: `point_p1` pulse in cycle 10 → `disp_sel`=1, `disp_addr`=0, `disp_data`=1 in cycle 12 only; `pend_p1` reads 1 in cycle 11 and 0 in cycle 12.
- Burst: 3 consecutive `point_p2` pulses → exactly 3 `disp_sel` pulses with `disp_addr`=1, 4 cycles apart; the display model reads P2 = 03.
- Tie: 2 pulses each, both players in the same cycles.
  - With the macro: grant order P1, P2, P1, P2.
  - Without the macro: P1, P1, P2, P2.
- Saturation (PEND_W=2): 5 `point_p1` pulses while the FSM is held in OVER by forcing `game_over` → no writes issued; `pend_p1` stays 0. Repeat in IDLE with the display write path stalled → `pend_p1` saturates at 3 and `ovf`=1.
- Game over (HOLD_CYCLES=8): drive P1 to 99 → no further `disp_sel` after the 99th write; OVER lasts 8 cycles; `game_rst`=1 for 1 cycle; display reads 00-00; `pend_*`=0; state IDLE.
- Reset mid-OVER: assert `rst` for 1 cycle in hold cycle 4 → no `game_rst` pulse; all outputs 0 on the next cycle.
